mandelbrot_iterator: RTL
========================

# mandelbrot_iterator

Iteration controller for one Mandelbrot point, directly downstream of `generator`. It holds the current z = (z_re, z_im), drives it into `generator`, and consumes `aa_minus_bb`, `two_ab` and `aa_plus_bb` to form z' = z² + c and test for escape. It counts iterations until escape or `MAX_ITER`, then presents the count on a valid/ready result port to the colour/pixel stage.

## Interface
- `MAX_ITER`, default 255: iteration limit; must satisfy 1 ≤ MAX_ITER ≤ 2^ITER_W − 1.
- `ITER_W`, default 8: width of the iteration counter.
- `FRAC_BITS`, default 21: fraction bits of the signed Q11.21 format shared with `generator`.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_valid` in 1: point request valid.
- `start_ready` out 1: block can accept a point; high only in IDLE.
- `c_re`, `c_im` in 32: c in Q11.21; sampled on the start handshake.
- `gen_a`, `gen_b` out 32: current z_re, z_im, wired to `generator.a` and `generator.b`.
- `aa_minus_bb`, `two_ab`, `aa_plus_bb` in 32: `generator` outputs for the current z.
- `result_valid` out 1: result available.
- `result_ready` in 1: downstream accepts the result.
- `iter_count` out ITER_W: iteration index at termination.
- `escaped` out 1: 1 if |z|² > 4.0 terminated the run; 0 if `MAX_ITER` was reached.

## Operation
- States:
  - IDLE: `start_ready` = 1.
  - ITER: one evaluation per cycle, or two with pipelining (see Configuration).
  - DONE: `result_valid` = 1, outputs held.
- Reset: state = IDLE. z_re, z_im, c regs, k, `iter_count`, `escaped`, `result_valid` all reset to 0; `start_ready` = 1.
- IDLE → ITER on `start_valid && start_ready`:
  - latch `c_re`, `c_im`;
  - set z = 0 and k = 0.
- Each ITER evaluation, in priority order:
  - If `aa_plus_bb` > 0x0080_0000 (4.0, signed compare, strict): DONE, with `iter_count` = k and `escaped` = 1.
  - Else if k == MAX_ITER: DONE, with `iter_count` = MAX_ITER and `escaped` = 0.
  - Else:
    - z_re ← `aa_minus_bb` + c_re;
    - z_im ← `two_ab` + c_im;
    - k ← k+1.
- Arithmetic: 32-bit two's-complement adds, wrap on overflow, no saturation. Results are exact for |c_re|, |c_im| < 16.0. Outside that range the values are undefined, but the run still terminates by the k == MAX_ITER rule.
- DONE → IDLE on `result_valid && result_ready`. `iter_count` and `escaped` stay stable while `result_ready` = 0.
- `start_valid` is ignored outside IDLE. A new point is not accepted in the same cycle as the result handshake.
- `rst` asserted in any state: IDLE at the next edge. An in-flight result is discarded, and nothing is emitted for that point.

## Timing
- `generator` is combinational, so the escape test and the z update for index k occur in the same cycle.
- Start handshake at edge T; escape or limit detected at index n:
  - `result_valid` rises after edge T+n+1.
  - Worst case is MAX_ITER+1 cycles.
- `start_ready` falls in the cycle after the accepted handshake.
- `start_ready` rises in the cycle after the result handshake.
- `gen_a`/`gen_b` change only at edges that start a run or update z.

## Configuration
- `MANDEL_GEN_PIPE_EN` defined:
  - `aa_minus_bb`, `two_ab` and `aa_plus_bb` are registered.
  - ITER splits into EVAL (capture) and UPDATE (escape test and z update using the registered values).
  - Two cycles per iteration; `result_valid` rises after edge T+2n+2.
  - Results are bit-identical to the unpipelined build.
- Not defined: single-cycle ITER as described above.

## Test plan
- c = (0, 0) → `escaped` = 0, `iter_count` = 255, `result_valid` after 256 cycles (512 with `MANDEL_GEN_PIPE_EN`).
- c = (0x0050_0000 = 2.5, 0):
  - z1 = 2.5, |z1|² = 6.25;
  - → `escaped` = 1, `iter_count` = 1, `result_valid` 2 cycles after accept.
- c = (0x0020_0000 = 1.0, 0):
  - z = 1, 2, 5; |z2|² = 4.0 does not escape (strict compare);
  - → `escaped` = 1, `iter_count` = 3.
- c = (0xFFC0_0000 = −2.0, 0):
  - z sticks at 2.0 with |z|² = 4.0 exactly;
  - → `escaped` = 0, `iter_count` = 255.
- c = 1.0 with `result_ready` held 0 for 10 cycles after `result_valid`:
  - `iter_count` = 3 and `escaped` = 1 stay stable;
  - `start_valid` is ignored while held;
  - after `result_ready` = 1, `start_ready` = 1 on the next cycle.
- `rst` pulsed for 1 cycle at k = 50 of a c = 0 run:
  - next cycle state = IDLE, `result_valid` = 0, `start_ready` = 1, `gen_a` = `gen_b` = 0;
  - a fresh c = 2.5 run then returns `iter_count` = 1.

Source files
------------

// File: rtl/mandelbrot_iterator.sv
// mandelbrot_iterator: iteration controller for a single Mandelbrot point.
// Holds z, feeds it to the combinational generator, forms z' = z^2 + c,
// tests |z|^2 > 4.0 and reports the iteration count on a valid/ready port.
// Optional feature macro: MANDEL_GEN_PIPE_EN registers the generator outputs
// and splits each iteration into an EVAL (capture) and UPDATE (test) cycle.
module mandelbrot_iterator #(
    parameter int unsigned MAX_ITER  = 255,
    parameter int unsigned ITER_W    = 8,
    parameter int unsigned FRAC_BITS = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [31:0]       c_re,
    input  logic [31:0]       c_im,
    output logic [31:0]       gen_a,
    output logic [31:0]       gen_b,
    input  logic [31:0]       aa_minus_bb,
    input  logic [31:0]       two_ab,
    input  logic [31:0]       aa_plus_bb,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [ITER_W-1:0] iter_count,
    output logic              escaped
);

    localparam int unsigned DATA_W = 32;
    localparam logic signed [DATA_W-1:0] ESC_LIMIT = DATA_W'(4) << FRAC_BITS;
    localparam logic [ITER_W-1:0] K_MAX = ITER_W'(MAX_ITER);

`ifdef MANDEL_GEN_PIPE_EN
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_UPDATE, S_DONE} state_t;
    localparam state_t S_RUN  = S_EVAL;
    localparam state_t S_TEST = S_UPDATE;
`else
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
    localparam state_t S_RUN  = S_ITER;
    localparam state_t S_TEST = S_ITER;
`endif

    state_t              state, state_n;
    logic [DATA_W-1:0]   c_re_q, c_re_n, c_im_q, c_im_n;
    logic [DATA_W-1:0]   z_re, z_re_n, z_im, z_im_n;
    logic [ITER_W-1:0]   k, k_n;
    logic                start_ready_n, result_valid_n, escaped_n;
    logic [ITER_W-1:0]   iter_count_n;
    logic [DATA_W-1:0]   ev_mb, ev_ab, ev_pb;
    logic                ev_escape, ev_limit;

`ifdef MANDEL_GEN_PIPE_EN
    logic [DATA_W-1:0]   mb_q, ab_q, pb_q;

    // Capture generator outputs for the current z; z is stable across EVAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            mb_q <= '0;
            ab_q <= '0;
            pb_q <= '0;
        end else begin
            mb_q <= aa_minus_bb;
            ab_q <= two_ab;
            pb_q <= aa_plus_bb;
        end
    end

    // Evaluation operands come from the capture registers.
    always_comb begin
        ev_mb = mb_q;
        ev_ab = ab_q;
        ev_pb = pb_q;
    end
`else
    // Evaluation operands come straight from the combinational generator.
    always_comb begin
        ev_mb = aa_minus_bb;
        ev_ab = two_ab;
        ev_pb = aa_plus_bb;
    end
`endif

    // Escape test is strict: |z|^2 == 4.0 keeps iterating.
    always_comb begin
        ev_escape = $signed(ev_pb) > ESC_LIMIT;
        ev_limit  = (k == K_MAX);
    end

    // Next-state and next-datapath logic for the control FSM.
    always_comb begin
        state_n        = state;
        c_re_n         = c_re_q;
        c_im_n         = c_im_q;
        z_re_n         = z_re;
        z_im_n         = z_im;
        k_n            = k;
        start_ready_n  = start_ready;
        result_valid_n = result_valid;
        iter_count_n   = iter_count;
        escaped_n      = escaped;
        case (state)
            S_IDLE: begin
                if (start_valid && start_ready) begin
                    c_re_n        = c_re;
                    c_im_n        = c_im;
                    z_re_n        = '0;
                    z_im_n        = '0;
                    k_n           = '0;
                    start_ready_n = 1'b0;
                    state_n       = S_RUN;
                end
            end
`ifdef MANDEL_GEN_PIPE_EN
            S_EVAL: begin
                state_n = S_UPDATE;
            end
`endif
            S_TEST: begin
                if (ev_escape) begin
                    iter_count_n   = k;
                    escaped_n      = 1'b1;
                    result_valid_n = 1'b1;
                    state_n        = S_DONE;
                end else if (ev_limit) begin
                    iter_count_n   = K_MAX;
                    escaped_n      = 1'b0;
                    result_valid_n = 1'b1;
                    state_n        = S_DONE;
                end else begin
                    z_re_n  = ev_mb + c_re_q;
                    z_im_n  = ev_ab + c_im_q;
                    k_n     = k + ITER_W'(1);
                    state_n = S_RUN;
                end
            end
            S_DONE: begin
                if (result_valid && result_ready) begin
                    result_valid_n = 1'b0;
                    start_ready_n  = 1'b1;
                    state_n        = S_IDLE;
                end
            end
            default: begin
                start_ready_n  = 1'b1;
                result_valid_n = 1'b0;
                state_n        = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            c_re_q       <= '0;
            c_im_q       <= '0;
            z_re         <= '0;
            z_im         <= '0;
            k            <= '0;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            iter_count   <= '0;
            escaped      <= 1'b0;
        end else begin
            state        <= state_n;
            c_re_q       <= c_re_n;
            c_im_q       <= c_im_n;
            z_re         <= z_re_n;
            z_im         <= z_im_n;
            k            <= k_n;
            start_ready  <= start_ready_n;
            result_valid <= result_valid_n;
            iter_count   <= iter_count_n;
            escaped      <= escaped_n;
        end
    end

    assign gen_a = z_re;
    assign gen_b = z_im;

endmodule
